alu_seq: RTL and testbench

- Parametrised successor of the team's strobe-loaded ALU.
- Operands A, B and the opcode arrive serially over one shared data bus. Each is captured by its own valid strobe, in any order.
- Once all three are held, the block issues one operation through a configurable result pipeline. It then presents a registered result, status flags and a one-cycle done pulse.
- Sits between the board-level input interface (switches or UART front-end) and the result display/transmit logic.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 71 +++++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and strobe indices for alu_seq
package alu_pkg;

  // Opcode width as defined by the MIPS funct field
  localparam int OPC_W = 6;

  // Supported opcodes (MIPS funct encoding)
  localparam logic [OPC_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OPC_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OPC_W-1:0] OP_AND = 6'b100100;
  localparam logic [OPC_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OPC_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OPC_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OPC_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OPC_W-1:0] OP_SRL = 6'b000010;

  // Bit positions inside the load-strobe vector
  localparam int VLD_A  = 0;
  localparam int VLD_B  = 1;
  localparam int VLD_OP = 2;

  // Pipeline cycle counter width, enough for up to 4 extra stages
  localparam int CNT_W = 3;

  // Sequencer states
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EXEC    = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath with carry, overflow and error flags
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int NB_OPERATION = 6
) (
  input  logic [NB_DATA-1:0]      i_a,
  input  logic [NB_DATA-1:0]      i_b,
  input  logic [NB_OPERATION-1:0] i_op,
  output logic [NB_DATA-1:0]      o_result,
  output logic                    o_carry,
  output logic                    o_overflow,
  output logic                    o_error
);

  localparam int LP_MSB = NB_DATA - 1;

  // Opcodes resized to the configured opcode field so every bit is compared
  localparam logic [NB_OPERATION-1:0] L_ADD = NB_OPERATION'(OP_ADD);
  localparam logic [NB_OPERATION-1:0] L_SUB = NB_OPERATION'(OP_SUB);
  localparam logic [NB_OPERATION-1:0] L_AND = NB_OPERATION'(OP_AND);
  localparam logic [NB_OPERATION-1:0] L_OR  = NB_OPERATION'(OP_OR);
  localparam logic [NB_OPERATION-1:0] L_XOR = NB_OPERATION'(OP_XOR);
  localparam logic [NB_OPERATION-1:0] L_NOR = NB_OPERATION'(OP_NOR);
  localparam logic [NB_OPERATION-1:0] L_SRA = NB_OPERATION'(OP_SRA);
  localparam logic [NB_OPERATION-1:0] L_SRL = NB_OPERATION'(OP_SRL);

  logic [NB_DATA:0]   w_sum;
  logic [NB_DATA:0]   w_diff;
  logic               w_shift_sat;
  logic [NB_DATA-1:0] w_srl;
  logic [NB_DATA-1:0] w_sra;

  // One extra bit on each side exposes carry-out and borrow directly
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Shift amounts at or beyond the word width saturate instead of wrapping
  assign w_shift_sat = (32'(i_b) >= 32'(NB_DATA));
  assign w_srl       = w_shift_sat ? '0 : (i_a >> i_b);
  assign w_sra       = w_shift_sat ? {NB_DATA{i_a[LP_MSB]}} : $unsigned($signed(i_a) >>> i_b);

  // Opcode decode; unsupported codes produce a zero result with the error flag
  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    o_error    = 1'b0;
    case (i_op)
      L_ADD: begin
        o_result   = w_sum[NB_DATA-1:0];
        o_carry    = w_sum[NB_DATA];
        o_overflow = (i_a[LP_MSB] == i_b[LP_MSB]) && (w_sum[LP_MSB] != i_a[LP_MSB]);
      end
      L_SUB: begin
        o_result   = w_diff[NB_DATA-1:0];
        o_carry    = w_diff[NB_DATA];
        o_overflow = (i_a[LP_MSB] != i_b[LP_MSB]) && (w_diff[LP_MSB] != i_a[LP_MSB]);
      end
      L_AND:   o_result = i_a & i_b;
      L_OR:    o_result = i_a | i_b;
      L_XOR:   o_result = i_a ^ i_b;
      L_NOR:   o_result = ~(i_a | i_b);
      L_SRA:   o_result = w_sra;
      L_SRL:   o_result = w_srl;
      default: o_error  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - serially loaded ALU with operand capture, issue FSM and result pipeline
module alu_seq
  import alu_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int NB_OPERATION = 6,
  parameter int PIPE_STAGES  = 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [2:0]          i_valid,
  output logic [NB_DATA-1:0]  o_result,
  output logic                o_zero,
  output logic                o_carry,
  output logic                o_overflow,
  output logic                o_error,
  output logic                o_valid,
  output logic                o_busy
);

  // Pipeline word layout: {error, overflow, carry, result}
  localparam int                LP_PW   = NB_DATA + 3;
  localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(PIPE_STAGES);

  state_t                   r_state;
  state_t                   w_state_next;

  logic [NB_DATA-1:0]       r_a;
  logic [NB_DATA-1:0]       r_b;
  logic [NB_OPERATION-1:0]  r_op;
  logic [2:0]               r_mask;
  logic [NB_DATA-1:0]       w_a_next;
  logic [NB_DATA-1:0]       w_b_next;
  logic [NB_OPERATION-1:0]  w_op_next;
  logic [2:0]               w_mask_next;

  logic [CNT_W-1:0]         r_cnt;
  logic [LP_PW-1:0]         r_pipe [0:PIPE_STAGES];

  logic [NB_DATA-1:0]       w_core_result;
  logic                     w_core_carry;
  logic                     w_core_overflow;
  logic                     w_core_error;

  logic                     w_collect;
  logic                     w_issue;
  logic                     w_done;

  logic [NB_DATA-1:0]       r_result;
  logic                     r_zero;
  logic                     r_carry;
  logic                     r_overflow;
  logic                     r_error;
  logic                     r_valid;

  // Field update as seen at the next edge, so the issue register sees this edge's strobes too
  always_comb begin
    w_a_next    = r_a;
    w_b_next    = r_b;
    w_op_next   = r_op;
    w_mask_next = r_mask;
    if (w_collect) begin
      if (i_valid[VLD_A])  w_a_next  = i_data;
      if (i_valid[VLD_B])  w_b_next  = i_data;
      if (i_valid[VLD_OP]) w_op_next = i_data[NB_OPERATION-1:0];
      w_mask_next = r_mask | i_valid;
    end
  end

  assign w_issue = w_collect && (&w_mask_next);

  // Operand/opcode capture and loaded mask; the mask empties when the op issues
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_mask <= '0;
    end else begin
      r_a    <= w_a_next;
      r_b    <= w_b_next;
      r_op   <= w_op_next;
      r_mask <= w_issue ? 3'b000 : w_mask_next;
    end
  end

  alu_core #(
    .NB_DATA      (NB_DATA),
    .NB_OPERATION (NB_OPERATION)
  ) u_core (
    .i_a        (w_a_next),
    .i_b        (w_b_next),
    .i_op       (w_op_next),
    .o_result   (w_core_result),
    .o_carry    (w_core_carry),
    .o_overflow (w_core_overflow),
    .o_error    (w_core_error)
  );

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= ST_COLLECT;
    else          r_state <= w_state_next;
  end

  // FSM next state: issue on a full mask, return once the pipeline has drained
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COLLECT: if (w_issue)           w_state_next = ST_EXEC;
      ST_EXEC:    if (r_cnt == LP_LAST)  w_state_next = ST_COLLECT;
      default:                           w_state_next = ST_COLLECT;
    endcase
  end

  // FSM outputs; busy stretches over the o_valid cycle even though strobes are accepted there
  always_comb begin
    w_collect = (r_state == ST_COLLECT);
    w_done    = (r_state == ST_EXEC) && (r_cnt == LP_LAST);
    o_busy    = (r_state == ST_EXEC) || r_valid;
  end

  // Cycles spent in EXEC, restarted whenever the FSM is collecting
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (w_collect || w_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Issue register at index 0 followed by PIPE_STAGES plain delay stages
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i <= PIPE_STAGES; i++) r_pipe[i] <= '0;
    end else begin
      if (w_issue) r_pipe[0] <= {w_core_error, w_core_overflow, w_core_carry, w_core_result};
      for (int i = 1; i <= PIPE_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Output registers load from the last stage on completion and hold otherwise
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        {r_error, r_overflow, r_carry, r_result} <= r_pipe[PIPE_STAGES];
        r_zero <= (r_pipe[PIPE_STAGES][NB_DATA-1:0] == '0);
      end
    end
  end

  assign o_result   = r_result;
  assign o_zero     = r_zero;
  assign o_carry    = r_carry;
  assign o_overflow = r_overflow;
  assign o_error    = r_error;
  assign o_valid    = r_valid;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq at pipe depths 0, 1 and 3
module tb_alu_seq;

  localparam int NB  = 8;
  localparam int NOP = 6;
  localparam int ND  = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NB-1:0]  data;
  logic [2:0]     vld;

  logic [NB-1:0]  res   [ND];
  logic           zero  [ND];
  logic           carry [ND];
  logic           ovf   [ND];
  logic           err   [ND];
  logic           ovld  [ND];
  logic           busy  [ND];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: captured fields, loaded mask, expected outputs {err,ovf,carry,zero,res}
  logic [NB-1:0]  m_a;
  logic [NB-1:0]  m_b;
  logic [NOP-1:0] m_op;
  logic [2:0]     m_mask;
  logic [NB+3:0]  e_old;
  logic [NB+3:0]  e_new;

  always #5 clk = ~clk;

  alu_seq #(.NB_DATA(NB), .NB_OPERATION(NOP), .PIPE_STAGES(0)) u_p0 (
    .i_clock(clk), .i_reset(rst_n), .i_data(data), .i_valid(vld),
    .o_result(res[0]), .o_zero(zero[0]), .o_carry(carry[0]), .o_overflow(ovf[0]),
    .o_error(err[0]), .o_valid(ovld[0]), .o_busy(busy[0]));

  alu_seq #(.NB_DATA(NB), .NB_OPERATION(NOP), .PIPE_STAGES(1)) u_p1 (
    .i_clock(clk), .i_reset(rst_n), .i_data(data), .i_valid(vld),
    .o_result(res[1]), .o_zero(zero[1]), .o_carry(carry[1]), .o_overflow(ovf[1]),
    .o_error(err[1]), .o_valid(ovld[1]), .o_busy(busy[1]));

  alu_seq #(.NB_DATA(NB), .NB_OPERATION(NOP), .PIPE_STAGES(3)) u_p3 (
    .i_clock(clk), .i_reset(rst_n), .i_data(data), .i_valid(vld),
    .o_result(res[2]), .o_zero(zero[2]), .o_carry(carry[2]), .o_overflow(ovf[2]),
    .o_error(err[2]), .o_valid(ovld[2]), .o_busy(busy[2]));

  function automatic int depth(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB+3:0] obs(input int d);
    return {err[d], ovf[d], carry[d], zero[d], res[d]};
  endfunction

  // Integer-arithmetic reference: signed overflow is an out-of-range check on the true result
  function automatic logic [NB+3:0] ref_alu(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                            input logic [NOP-1:0] op);
    int ua, ub, sa, sb, s, sr, full;
    logic [NB-1:0] r;
    logic c, v, e;
    full = 1 << NB;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= full / 2) ? ua - full : ua;
    sb = (ub >= full / 2) ? ub - full : ub;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      6'h20: begin s = ua + ub; r = NB'(s); c = (s >= full); sr = sa + sb;
                   v = (sr >= full / 2) || (sr < -(full / 2)); end
      6'h22: begin s = ua - ub; r = NB'(s); c = (ua < ub); sr = sa - sb;
                   v = (sr >= full / 2) || (sr < -(full / 2)); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h03: r = (ub >= NB) ? ((sa < 0) ? '1 : '0) : NB'(sa >>> ub);
      6'h02: r = (ub >= NB) ? '0 : NB'(ua >> ub);
      default: e = 1'b1;
    endcase
    return {e, v, c, (r == '0), r};
  endfunction

  function automatic logic [NB-1:0] rand_data(input bit want_op);
    logic [NB-1:0] d;
    d = NB'($urandom);
    if (want_op && ($urandom_range(0, 7) != 0)) begin
      case ($urandom_range(0, 7))
        0: d[NOP-1:0] = 6'h20;
        1: d[NOP-1:0] = 6'h22;
        2: d[NOP-1:0] = 6'h24;
        3: d[NOP-1:0] = 6'h25;
        4: d[NOP-1:0] = 6'h26;
        5: d[NOP-1:0] = 6'h27;
        6: d[NOP-1:0] = 6'h03;
        default: d[NOP-1:0] = 6'h02;
      endcase
    end else if (!want_op) begin
      case ($urandom_range(0, 5))
        0: d = 8'h00;
        1: d = 8'h7F;
        2: d = 8'h80;
        3: d = 8'hFF;
        4: d = NB'($urandom_range(0, 12));
        default: d = NB'($urandom);
      endcase
    end
    return d;
  endfunction

  // One strobe cycle; when it does not complete the mask, every instance must stay idle and hold
  task automatic strobe(input logic [2:0] v, input logic [NB-1:0] d, output bit issued);
    vld  = v;
    data = d;
    if (v[0]) m_a  = d;
    if (v[1]) m_b  = d;
    if (v[2]) m_op = d[NOP-1:0];
    m_mask = m_mask | v;
    issued = (m_mask == 3'b111);
    if (issued) begin
      m_mask = '0;
      e_new  = ref_alu(m_a, m_b, m_op);
    end
    @(negedge clk);
    vld  = '0;
    data = NB'($urandom);
    if (!issued) begin
      for (int d2 = 0; d2 < ND; d2++) begin
        check($sformatf("idle_valid_p%0d", depth(d2)), 32'(ovld[d2]), 32'd0);
        check($sformatf("idle_busy_p%0d", depth(d2)), 32'(busy[d2]), 32'd0);
        check($sformatf("idle_hold_p%0d", depth(d2)), 32'(obs(d2)), 32'(e_old));
      end
    end
  endtask

  // Sampled from the negedge after the issuing edge: k counts edges since that edge
  task automatic window(input bit garbage);
    for (int k = 0; k <= 5; k++) begin
      for (int d = 0; d < ND; d++) begin
        int p;
        p = depth(d);
        check($sformatf("valid_p%0d_k%0d", p, k), 32'(ovld[d]), 32'(k == p + 1));
        check($sformatf("busy_p%0d_k%0d", p, k), 32'(busy[d]), 32'(k <= p + 1));
        check($sformatf("out_p%0d_k%0d", p, k), 32'(obs(d)), (k >= p + 1) ? 32'(e_new) : 32'(e_old));
      end
      if (k == 0 && garbage) begin
        vld  = 3'($urandom_range(1, 7));
        data = NB'($urandom);
      end else begin
        vld = '0;
      end
      @(negedge clk);
    end
    vld   = '0;
    e_old = e_new;
  endtask

  task automatic load(input logic [2:0] v, input logic [NB-1:0] d);
    bit iss;
    strobe(v, d, iss);
    if (iss) window(1'($urandom_range(0, 1)));
  endtask

  task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [NB-1:0] op, input bit reverse);
    if (!reverse) begin
      load(3'b001, a); load(3'b010, b); load(3'b100, op);
    end else begin
      load(3'b100, op); load(3'b010, b); load(3'b001, a);
    end
  endtask

  task automatic pull_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_out_p%0d", depth(d)), 32'(obs(d)), 32'd0);
      check($sformatf("rst_valid_p%0d", depth(d)), 32'(ovld[d]), 32'd0);
      check($sformatf("rst_busy_p%0d", depth(d)), 32'(busy[d]), 32'd0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    m_a    = '0;
    m_b    = '0;
    m_op   = '0;
    m_mask = '0;
    e_old  = '0;
  endtask

  initial begin
    bit            iss;
    int            tries;
    logic [2:0]    v;
    logic [NB-1:0] d;

    rst_n  = 1'b0;
    vld    = '0;
    data   = '0;
    m_a    = '0;
    m_b    = '0;
    m_op   = '0;
    m_mask = '0;
    e_old  = '0;
    e_new  = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("reset_out_p%0d", depth(i)), 32'(obs(i)), 32'd0);
      check($sformatf("reset_valid_p%0d", depth(i)), 32'(ovld[i]), 32'd0);
      check($sformatf("reset_busy_p%0d", depth(i)), 32'(busy[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'd3, 8'd4, 8'hA0, 1'b0);
    check("add_3_4", 32'(res[1]), 32'h07);
    do_op(8'd3, 8'd4, 8'h22, 1'b1);
    check("sub_3_4", 32'(res[1]), 32'hFF);
    check("sub_3_4_borrow", 32'(carry[1]), 32'd1);
    do_op(8'h7F, 8'h01, 8'h20, 1'b0);
    check("add_7f_1", 32'(res[1]), 32'h80);
    check("add_7f_1_ovf", 32'(ovf[1]), 32'd1);

    load(3'b011, 8'd5);
    load(3'b100, 8'h22);
    check("sub_5_5_zero", 32'(zero[1]), 32'd1);
    do_op(8'h80, 8'd2, 8'h03, 1'b0);
    check("sra_80_2", 32'(res[1]), 32'hE0);
    do_op(8'h80, 8'd9, 8'h02, 1'b1);
    check("srl_80_9", 32'(res[1]), 32'h00);
    do_op(8'h12, 8'h34, 8'h3F, 1'b0);
    check("bad_op_err", 32'(err[1]), 32'd1);

    strobe(3'b001, 8'd10, iss);
    strobe(3'b010, 8'd20, iss);
    strobe(3'b100, 8'h20, iss);
    window(1'b1);
    check("add_after_err", 32'(err[1]), 32'd0);
    check("add_10_20", 32'(res[1]), 32'd30);

    strobe(3'b001, 8'h55, iss);
    strobe(3'b010, 8'h66, iss);
    strobe(3'b100, 8'h20, iss);
    pull_reset();
    repeat (4) strobe(3'b000, 8'h00, iss);

    strobe(3'b001, 8'h11, iss);
    strobe(3'b010, 8'h22, iss);
    pull_reset();
    strobe(3'b100, 8'h26, iss);
    strobe(3'b010, 8'h0F, iss);
    load(3'b001, 8'hF0);
    check("xor_after_reset", 32'(res[1]), 32'hFF);

    for (int n = 0; n < 60; n++) begin
      iss   = 1'b0;
      tries = 0;
      while (!iss) begin
        v = (tries >= 12) ? 3'b111 : 3'($urandom_range(0, 7));
        d = rand_data(v[2]);
        strobe(v, d, iss);
        tries++;
      end
      window(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
